// File: rtl/dmem_arbiter.sv
// Data-memory arbiter for the RV32 pipeline: shares one fixed-latency memory port
// between the MEM-stage core path and a debug/loader port, stalling the core until done.
module dmem_arbiter #(
    parameter int ADDR_W   = 8,
    parameter int MEM_LAT  = 1,
    parameter int MAX_WAIT = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [31:0]       core_wdata,
    output logic [31:0]       core_rdata,
    output logic              core_stall,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [31:0]       dbg_wdata,
    output logic              dbg_ack,
    output logic [31:0]       dbg_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic [1:0]        fsm_state
);

    localparam int LAT_W  = $clog2(MEM_LAT + 1);
    localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state;
    logic              owner_dbg;
    logic [LAT_W-1:0]  lat_cnt;
    logic [WAIT_W-1:0] wait_cnt;

    logic dbg_force;
    logic grant_dbg;
    logic grant_any;
    logic dbg_in_service;

    // Handshakes: core_req is held until the DONE cycle in which core_stall drops;
    // dbg_req is held until the single-cycle dbg_ack pulse.
    assign dbg_force      = dbg_req && (wait_cnt >= WAIT_W'(MAX_WAIT));
    assign grant_dbg      = dbg_force || (dbg_req && !core_req);
    assign grant_any      = core_req || dbg_req;
    assign dbg_in_service = (state != S_IDLE) && owner_dbg;

    assign core_stall = core_req && !((state == S_DONE) && !owner_dbg);
    assign fsm_state  = state;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            owner_dbg  <= 1'b0;
            lat_cnt    <= '0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            core_rdata <= '0;
            dbg_rdata  <= '0;
            dbg_ack    <= 1'b0;
        end else begin
            mem_en  <= 1'b0;
            mem_we  <= 1'b0;
            dbg_ack <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (grant_any) begin
                        owner_dbg <= grant_dbg;
                        mem_addr  <= grant_dbg ? dbg_addr  : core_addr;
                        mem_wdata <= grant_dbg ? dbg_wdata : core_wdata;
                        mem_we    <= grant_dbg ? dbg_we    : core_we;
                        mem_en    <= 1'b1;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // mem_we still holds the granted request's direction here
                    if (mem_we) begin
                        dbg_ack <= owner_dbg;
                        state   <= S_DONE;
                    end else begin
                        lat_cnt <= LAT_W'(MEM_LAT);
                        state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    lat_cnt <= lat_cnt - 1'b1;
                    if (lat_cnt == LAT_W'(1)) begin
                        if (owner_dbg) dbg_rdata <= mem_rdata;
                        else           core_rdata <= mem_rdata;
                        dbg_ack <= owner_dbg;
                        state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Starvation guard: counts cycles a waiting debug request is passed over.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if (!dbg_req || ((state == S_IDLE) && grant_dbg)) begin
            wait_cnt <= '0;
        end else if (!dbg_in_service && (wait_cnt < WAIT_W'(MAX_WAIT))) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: two instances (MEM_LAT=1 and MEM_LAT=3) share stimulus,
// each with its own byte-addressed memory model; use3 selects which one is observed.
module tb_dmem_arbiter;

    logic        clock;
    logic        reset;
    logic        core_req;
    logic        core_we;
    logic [7:0]  core_addr;
    logic [31:0] core_wdata;
    logic        dbg_req;
    logic        dbg_we;
    logic [7:0]  dbg_addr;
    logic [31:0] dbg_wdata;

    logic [31:0] core_rdata_1, core_rdata_3, dbg_rdata_1, dbg_rdata_3;
    logic        core_stall_1, core_stall_3, dbg_ack_1, dbg_ack_3;
    logic        mem_en_1, mem_en_3, mem_we_1, mem_we_3;
    logic [7:0]  mem_addr_1, mem_addr_3;
    logic [31:0] mem_wdata_1, mem_wdata_3, mem_rdata_1, mem_rdata_3;
    logic [1:0]  fsm_state_1, fsm_state_3;

    int errors = 0;
    int checks = 0;
    logic use3 = 1'b0;

    dmem_arbiter #(.ADDR_W(8), .MEM_LAT(1), .MAX_WAIT(4)) dut1 (
        .clock(clock), .reset(reset),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_rdata(core_rdata_1), .core_stall(core_stall_1),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack_1), .dbg_rdata(dbg_rdata_1),
        .mem_en(mem_en_1), .mem_we(mem_we_1), .mem_addr(mem_addr_1), .mem_wdata(mem_wdata_1),
        .mem_rdata(mem_rdata_1), .fsm_state(fsm_state_1)
    );

    dmem_arbiter #(.ADDR_W(8), .MEM_LAT(3), .MAX_WAIT(4)) dut3 (
        .clock(clock), .reset(reset),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_rdata(core_rdata_3), .core_stall(core_stall_3),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack_3), .dbg_rdata(dbg_rdata_3),
        .mem_en(mem_en_3), .mem_we(mem_we_3), .mem_addr(mem_addr_3), .mem_wdata(mem_wdata_3),
        .mem_rdata(mem_rdata_3), .fsm_state(fsm_state_3)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // observed instance
    wire        stall_s  = use3 ? core_stall_3 : core_stall_1;
    wire        en_s     = use3 ? mem_en_3     : mem_en_1;
    wire        we_s     = use3 ? mem_we_3     : mem_we_1;
    wire [7:0]  addr_s   = use3 ? mem_addr_3   : mem_addr_1;
    wire [31:0] wdata_s  = use3 ? mem_wdata_3  : mem_wdata_1;
    wire [31:0] crd_s    = use3 ? core_rdata_3 : core_rdata_1;
    wire        ack_s    = use3 ? dbg_ack_3    : dbg_ack_1;
    wire [31:0] drd_s    = use3 ? dbg_rdata_3  : dbg_rdata_1;
    wire [1:0]  state_s  = use3 ? fsm_state_3  : fsm_state_1;

    // memory models: little-endian bytes, preloaded while reset is low
    logic [7:0]  mem1 [256];
    logic [7:0]  mem3 [256];
    logic [31:0] p3_0, p3_1, p3_2;
    wire  [7:0]  a1_1 = mem_addr_1 + 8'd1, a1_2 = mem_addr_1 + 8'd2, a1_3 = mem_addr_1 + 8'd3;
    wire  [7:0]  a3_1 = mem_addr_3 + 8'd1, a3_2 = mem_addr_3 + 8'd2, a3_3 = mem_addr_3 + 8'd3;
    assign mem_rdata_3 = p3_2;

    always @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < 256; i++) begin
                mem1[i] <= 8'h00;
                mem3[i] <= 8'h00;
            end
            mem1[8'h28] <= 8'hFF; mem1[8'h29] <= 8'h00; mem1[8'h2A] <= 8'hFF; mem1[8'h2B] <= 8'h00;
            mem1[8'h2C] <= 8'h78; mem1[8'h2D] <= 8'h56; mem1[8'h2E] <= 8'h34; mem1[8'h2F] <= 8'h12;
            mem1[8'h10] <= 8'h6D;
            mem3[8'h28] <= 8'hFF; mem3[8'h29] <= 8'h00; mem3[8'h2A] <= 8'hFF; mem3[8'h2B] <= 8'h00;
            mem3[8'h2C] <= 8'h78; mem3[8'h2D] <= 8'h56; mem3[8'h2E] <= 8'h34; mem3[8'h2F] <= 8'h12;
            mem3[8'h10] <= 8'h6D;
            mem_rdata_1 <= 32'h0;
            p3_0 <= 32'h0; p3_1 <= 32'h0; p3_2 <= 32'h0;
        end else begin
            if (mem_en_1 && mem_we_1) begin
                mem1[mem_addr_1] <= mem_wdata_1[7:0];   mem1[a1_1] <= mem_wdata_1[15:8];
                mem1[a1_2]       <= mem_wdata_1[23:16]; mem1[a1_3] <= mem_wdata_1[31:24];
            end
            if (mem_en_3 && mem_we_3) begin
                mem3[mem_addr_3] <= mem_wdata_3[7:0];   mem3[a3_1] <= mem_wdata_3[15:8];
                mem3[a3_2]       <= mem_wdata_3[23:16]; mem3[a3_3] <= mem_wdata_3[31:24];
            end
            mem_rdata_1 <= mem_en_1 ? {mem1[a1_3], mem1[a1_2], mem1[a1_1], mem1[mem_addr_1]} : 32'h0;
            p3_0 <= mem_en_3 ? {mem3[a3_3], mem3[a3_2], mem3[a3_1], mem3[mem_addr_3]} : 32'h0;
            p3_1 <= p3_0;
            p3_2 <= p3_1;
        end
    end

    // driver tasks
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic core_access(input logic we, input logic [7:0] addr, input logic [31:0] wdata,
                               output int n_stall, output int n_en, output int en_at,
                               output logic en_we, output logic [7:0] en_addr,
                               output logic [31:0] en_wdata, output logic [31:0] rdata,
                               output logic saw_wait, output logic timed_out);
        logic done;
        core_req = 1'b1; core_we = we; core_addr = addr; core_wdata = wdata;
        #1;
        n_stall = 0; n_en = 0; en_at = -1; en_we = 1'b0; en_addr = 8'h0; en_wdata = 32'h0;
        rdata = 32'h0; saw_wait = 1'b0; done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            if (en_s) begin
                n_en++; en_at = i; en_we = we_s; en_addr = addr_s; en_wdata = wdata_s;
            end
            if (state_s == 2'd2) saw_wait = 1'b1;
            if (stall_s) begin
                n_stall++;
                step(1);
            end else begin
                rdata = crd_s;
                core_req = 1'b0;
                done = 1'b1;
            end
        end
        core_req = 1'b0;
        timed_out = !done;
    endtask

    // scenarios
    task automatic test_reset();
        core_req = 0; core_we = 0; core_addr = 0; core_wdata = 0;
        dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
        reset = 1'b0;
        step(3);
        for (int s = 0; s < 2; s++) begin
            use3 = (s == 1);
            #1;
            checks++;
            if ({en_s, we_s, addr_s, wdata_s} !== 42'h0) begin
                errors++;
                $display("FAIL reset_mem[%0d]: en=%b we=%b addr=%h wdata=%h, required all 0", s, en_s, we_s, addr_s, wdata_s);
            end
            checks++;
            if ({crd_s, drd_s, ack_s, stall_s} !== 66'h0) begin
                errors++;
                $display("FAIL reset_out[%0d]: core_rdata=%h dbg_rdata=%h ack=%b stall=%b, required all 0", s, crd_s, drd_s, ack_s, stall_s);
            end
            checks++;
            if (state_s !== 2'd0) begin
                errors++;
                $display("FAIL reset_state[%0d]: got %0d required 0", s, state_s);
            end
        end
        use3 = 1'b0;
        reset = 1'b1;
        step(2);
    endtask

    task automatic test_load();
        int n_stall, n_en, en_at; logic en_we, saw_wait, to; logic [7:0] ea; logic [31:0] ew, rd;
        use3 = 1'b0;
        core_access(1'b0, 8'h28, 32'h0, n_stall, n_en, en_at, en_we, ea, ew, rd, saw_wait, to);
        checks++;
        if (to || n_stall != 3) begin
            errors++; $display("FAIL load_stall: got %0d cycles (timeout=%b) required 3", n_stall, to);
        end
        checks++;
        if (n_en != 1 || en_at != 1 || en_we !== 1'b0 || ea !== 8'h28) begin
            errors++; $display("FAIL load_issue: en_count=%0d at=%0d we=%b addr=%h required 1 at 1 we=0 addr=28", n_en, en_at, en_we, ea);
        end
        checks++;
        if (rd !== 32'h00FF00FF) begin
            errors++; $display("FAIL load_rdata: got %h required 00ff00ff", rd);
        end
        step(8);
    endtask

    task automatic test_store();
        int n_stall, n_en, en_at; logic en_we, saw_wait, to; logic [7:0] ea; logic [31:0] ew, rd;
        use3 = 1'b0;
        core_access(1'b1, 8'd100, 32'h00FF01FF, n_stall, n_en, en_at, en_we, ea, ew, rd, saw_wait, to);
        checks++;
        if (to || n_stall != 2 || saw_wait) begin
            errors++; $display("FAIL store_stall: got %0d cycles wait_seen=%b timeout=%b required 2, no wait", n_stall, saw_wait, to);
        end
        checks++;
        if (n_en != 1 || en_we !== 1'b1 || ea !== 8'd100 || ew !== 32'h00FF01FF) begin
            errors++; $display("FAIL store_issue: en_count=%0d we=%b addr=%0d wdata=%h required 1 1 100 00ff01ff", n_en, en_we, ea, ew);
        end
        checks++;
        if ({mem1[100], mem1[101], mem1[102], mem1[103]} !== 32'hFF01FF00) begin
            errors++; $display("FAIL store_bytes: got %h %h %h %h required ff 01 ff 00", mem1[100], mem1[101], mem1[102], mem1[103]);
        end
        step(8);
    endtask

    task automatic test_back_to_back();
        int n_en, dones; int en_at [2]; logic [31:0] r1, r2;
        use3 = 1'b0;
        core_req = 1'b1; core_we = 1'b0; core_addr = 8'h28;
        #1;
        n_en = 0; dones = 0; en_at[0] = -1; en_at[1] = -1; r1 = 0; r2 = 0;
        for (int i = 0; i < 20 && dones < 2; i++) begin
            if (en_s) begin
                if (n_en < 2) en_at[n_en] = i;
                n_en++;
            end
            if (!stall_s) begin
                dones++;
                if (dones == 1) begin r1 = crd_s; core_addr = 8'h2C; end
                else begin r2 = crd_s; core_req = 1'b0; end
            end
            if (dones < 2) step(1);
        end
        core_req = 1'b0;
        checks++;
        if (n_en != 2 || en_at[0] != 1 || en_at[1] != 5 || dones != 2) begin
            errors++; $display("FAIL b2b_issue: count=%0d at %0d,%0d dones=%0d required 2 at 1,5 dones=2", n_en, en_at[0], en_at[1], dones);
        end
        checks++;
        if (r1 !== 32'h00FF00FF || r2 !== 32'h12345678) begin
            errors++; $display("FAIL b2b_rdata: got %h,%h required 00ff00ff,12345678", r1, r2);
        end
        step(8);
    endtask

    task automatic test_contention();
        int core_before, dbg_en_at, n_ack, ack_at, stall_gap; logic [31:0] ack_data; logic finished;
        use3 = 1'b0;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 8'h10; dbg_wdata = 32'h0;
        core_req = 1'b1; core_we = 1'b1; core_addr = 8'h40; core_wdata = 32'hA5A50001;
        #1;
        core_before = 0; dbg_en_at = -1; n_ack = 0; ack_at = -1; stall_gap = 0;
        ack_data = 32'h0; finished = 1'b0;
        for (int i = 0; i < 24 && !finished; i++) begin
            if (en_s) begin
                if (!we_s) dbg_en_at = i;
                else if (dbg_en_at < 0) core_before++;
            end
            if (i >= 6 && i <= 9 && !stall_s) stall_gap++;
            if (ack_s) begin
                n_ack++; ack_at = i; ack_data = drd_s; dbg_req = 1'b0;
            end
            if (!stall_s && n_ack > 0) begin
                core_req = 1'b0; finished = 1'b1;
            end
            if (!finished) step(1);
        end
        core_req = 1'b0; dbg_req = 1'b0;
        checks++;
        if (core_before != 2 || dbg_en_at != 7) begin
            errors++; $display("FAIL contention_grant: core wins=%0d dbg issue at %0d required 2 and 7", core_before, dbg_en_at);
        end
        checks++;
        if (n_ack != 1 || ack_at != 9 || ack_data !== 32'h0000006D) begin
            errors++; $display("FAIL contention_ack: acks=%0d at %0d data=%h required 1 at 9 data 0000006d", n_ack, ack_at, ack_data);
        end
        checks++;
        if (stall_gap != 0 || !finished) begin
            errors++; $display("FAIL contention_stall: unstalled cycles=%0d finished=%b required 0 and 1", stall_gap, finished);
        end
        step(8);
    endtask

    task automatic test_reset_mid_wait();
        int n_stall, n_en, en_at, stray; logic en_we, saw_wait, to; logic [7:0] ea; logic [31:0] ew, rd;
        reset = 1'b0; core_req = 1'b0; dbg_req = 1'b0;
        step(2);
        reset = 1'b1;
        step(2);
        use3 = 1'b1;
        core_access(1'b0, 8'h2C, 32'h0, n_stall, n_en, en_at, en_we, ea, ew, rd, saw_wait, to);
        checks++;
        if (to || n_stall != 5 || rd !== 32'h12345678) begin
            errors++; $display("FAIL lat3_load: stall=%0d rdata=%h timeout=%b required 5 and 12345678", n_stall, rd, to);
        end
        step(2);
        core_req = 1'b1; core_we = 1'b0; core_addr = 8'h28;
        step(3);
        checks++;
        if (state_s !== 2'd2) begin
            errors++; $display("FAIL rmw_pre_state: got %0d required 2", state_s);
        end
        reset = 1'b0; core_req = 1'b0;
        #1;
        checks++;
        if (state_s !== 2'd0 || en_s !== 1'b0 || crd_s !== 32'h0 || ack_s !== 1'b0) begin
            errors++; $display("FAIL rmw_reset: state=%0d en=%b core_rdata=%h ack=%b required 0 0 0 0", state_s, en_s, crd_s, ack_s);
        end
        step(2);
        reset = 1'b1;
        stray = 0;
        for (int i = 0; i < 5; i++) begin
            if (en_s || ack_s || crd_s != 32'h0) stray++;
            step(1);
        end
        checks++;
        if (stray != 0) begin
            errors++; $display("FAIL rmw_no_done: stray activity cycles=%0d required 0", stray);
        end
        core_access(1'b0, 8'h28, 32'h0, n_stall, n_en, en_at, en_we, ea, ew, rd, saw_wait, to);
        checks++;
        if (to || n_stall != 5 || n_en != 1 || en_at != 1 || rd !== 32'h00FF00FF) begin
            errors++; $display("FAIL rmw_fresh_load: stall=%0d en=%0d at %0d rdata=%h required 5 1 1 00ff00ff", n_stall, n_en, en_at, rd);
        end
        step(2);
    endtask

    task automatic test_dbg_lat3();
        int ack_at, en_at; logic [31:0] ack_data;
        use3 = 1'b1;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 8'h10;
        #1;
        ack_at = -1; en_at = -1; ack_data = 32'h0;
        for (int i = 0; i < 16 && ack_at < 0; i++) begin
            if (en_s && en_at < 0) en_at = i;
            if (ack_s) begin
                ack_at = i; ack_data = drd_s; dbg_req = 1'b0;
            end else begin
                step(1);
            end
        end
        dbg_req = 1'b0;
        checks++;
        if (en_at != 1 || ack_at != 5 || ack_data !== 32'h0000006D) begin
            errors++; $display("FAIL dbg_lat3: issue at %0d ack at %0d data=%h required 1, 5, 0000006d", en_at, ack_at, ack_data);
        end
        step(3);
        checks++;
        if (drd_s !== 32'h0000006D || ack_s !== 1'b0 || stall_s !== 1'b0) begin
            errors++; $display("FAIL dbg_hold: dbg_rdata=%h ack=%b stall=%b required 0000006d 0 0", drd_s, ack_s, stall_s);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_store();
        test_back_to_back();
        test_contention();
        test_reset_mid_wait();
        test_dbg_lat3();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
